uartwb_burst_control: RTL and testbench
=======================================

UARTWB_BURST_CONTROL -- requirements
Module: uartwb_burst_control

Interface
REQ-001 SHALL have parameter ADDR_WID, default 32: Wishbone address width in bits, multiple of 8, 8..64.
REQ-002 SHALL have parameter DATA_WID, default 32: data word width in bits, multiple of 8, 8..64.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum words per frame, 1..255.
REQ-004 SHALL have parameter RX_TIMEOUT, default 100000: inter-byte timeout in clk_i cycles.
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port nrst_i, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port uartrx_valid_i, input, 1: a rising edge marks a new rx byte.
REQ-008 SHALL have port uartrx_data_i, input, 8: the rx byte.
REQ-009 SHALL have port uarttx_ready_i, input, 1: tx buffer can accept a byte.
REQ-010 SHALL have port uarttx_en_o, output, 1: one-cycle tx strobe.
REQ-011 SHALL have port uarttx_data_o, output, 8: the tx byte.
REQ-012 SHALL have port wrapper_wr_o, output, 1: 1 = write, 0 = read.
REQ-013 SHALL have port wrapper_en_o, output, 1: one-cycle access request.
REQ-014 SHALL have port wrapper_valid_i, input, 1: access complete.
REQ-015 SHALL have ports wrapper_addr_o (ADDR_WID), wrapper_data_o (DATA_WID), outputs; wrapper_data_i (DATA_WID), input.
REQ-016 SHALL have ports cmdrx_ctr and err_ctr, outputs, 8 each: frame and error counters, wrapping.

Function
REQ-017 Frame format SHALL be CMD, LEN, then ADDR (ADDR_WID/8 bytes, MSB first), then LEN×DATA_WID/8 data bytes (writes only, word-serial, MSB first), then CHK.
REQ-018 CMD 0x01 SHALL select a write; any other value SHALL select a read.
REQ-019 CHK SHALL equal 0xFF XOR all preceding bytes of the frame.
REQ-020 The rx strobe SHALL be uartrx_valid_i high while the previous-cycle sample was low; the sample register SHALL reset to 1.
REQ-021 States SHALL be IDLE, RX_LEN, RX_ADDR, RX_DATA, RX_CHK, CHECK, WB_REQ, WB_WAIT, TX_CMD, TX_DATA.
REQ-022 CHECK SHALL take one cycle after CHK; on checksum mismatch the response SHALL be 0xFF; on LEN=0 or LEN>MAX_BURST it SHALL be 0xFE; in both cases the block SHALL go to TX_CMD with no Wishbone access and err_ctr+1.
REQ-023 Write data SHALL be buffered in full; no write SHALL be issued before CHECK passes.
REQ-024 For word i (0..LEN-1), wrapper_addr_o SHALL be ADDR + i×DATA_WID/8, modulo 2^ADDR_WID.
REQ-025 wrapper_en_o SHALL pulse in the cycle after entry to WB_REQ; WB_WAIT SHALL hold until wrapper_valid_i; wr/addr/data SHALL stay stable from the pulse until valid.
REQ-026 Write: after all LEN words, TX_CMD SHALL emit the CMD echo; then IDLE.
REQ-027 Read: TX_CMD SHALL run once before the first word; each word SHALL be captured on wrapper_valid_i and emitted in TX_DATA (DATA_WID/8 bytes, MSB first) before the next WB_REQ; then IDLE.
REQ-028 uarttx_en_o SHALL pulse exactly once per byte, only in a cycle where uarttx_ready_i=1; otherwise the FSM SHALL hold.
REQ-029 Rx strobes outside the RX_* states and IDLE SHALL be ignored.
REQ-030 cmdrx_ctr SHALL increment on every CMD byte accepted in IDLE.

Reset
REQ-031 nrst_i low SHALL force IDLE immediately, even mid-frame or mid-access.
REQ-032 Reset values: uarttx_en_o, wrapper_en_o, wrapper_wr_o 0; all data/address outputs 0; counters 0; timeout counter 0.

Configuration
REQ-033 With UARTWB_RXTIMEOUT_EN defined, RX_TIMEOUT cycles without a strobe in RX_LEN..RX_CHK SHALL return the block to IDLE silently with err_ctr+1.
REQ-034 Without UARTWB_RXTIMEOUT_EN, the block SHALL wait indefinitely, and RX_TIMEOUT SHALL have no effect.

Structure
REQ-035 Package uartwb_pkg SHALL hold the CMD codes (0x00, 0x01), the status codes (0xFE, 0xFF), the state encoding and the checksum seed 0xFF.
REQ-036 The write buffer SHALL be sub-module uartwb_wbuf: MAX_BURST×DATA_WID, write pointer and read pointer, cleared on frame start.

Verification
REQ-037 Write, LEN=2, ADDR=0x1000, data 0xA5A5A5A5 and 0x5A5A5A5A, correct CHK -> writes at 0x1000 and 0x1004, then tx 0x01.
REQ-038 Read, LEN=3, ADDR=0x20, slave returns 1,2,3 -> tx 0x00 followed by 12 bytes, with reads at 0x20, 0x24, 0x28.
REQ-039 Write with bad CHK -> no wrapper_en_o pulse, tx 0xFF, err_ctr=1.
REQ-040 LEN=0, then LEN=MAX_BURST+1 -> tx 0xFE each time, no access; LEN=MAX_BURST -> success.
REQ-041 uarttx_ready_i low for 50 cycles during a read reply -> no lost or duplicated bytes.
REQ-042 With UARTWB_RXTIMEOUT_EN, stop after the ADDR bytes -> IDLE after RX_TIMEOUT cycles, no tx, err_ctr+1; nrst_i asserted in WB_WAIT -> IDLE, wrapper_en_o=0.

Source files
------------

// File: rtl/uartwb_pkg.sv
// Shared constants for the UART-to-Wishbone burst bridge: command and status
// codes, checksum seed and the FSM state encoding.
package uartwb_pkg;

  localparam logic [7:0] CMD_READ   = 8'h00;
  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] ST_BADLEN  = 8'hFE;
  localparam logic [7:0] ST_BADCHK  = 8'hFF;
  localparam logic [7:0] CHK_SEED   = 8'hFF;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RX_LEN  = 4'd1;
  localparam logic [3:0] S_RX_ADDR = 4'd2;
  localparam logic [3:0] S_RX_DATA = 4'd3;
  localparam logic [3:0] S_RX_CHK  = 4'd4;
  localparam logic [3:0] S_CHECK   = 4'd5;
  localparam logic [3:0] S_WB_REQ  = 4'd6;
  localparam logic [3:0] S_WB_WAIT = 4'd7;
  localparam logic [3:0] S_TX_CMD  = 4'd8;
  localparam logic [3:0] S_TX_DATA = 4'd9;

endpackage

// File: rtl/uartwb_burst_control_if.sv
// UART byte stream and Wishbone wrapper signals of the burst bridge.
// master = the bridge, slave = the UART/bus environment around it.
interface uartwb_burst_control_if #(
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 32
) ();

  logic                uartrx_valid_i;
  logic [7:0]          uartrx_data_i;
  logic                uarttx_ready_i;
  logic                uarttx_en_o;
  logic [7:0]          uarttx_data_o;
  logic                wrapper_wr_o;
  logic                wrapper_en_o;
  logic                wrapper_valid_i;
  logic [ADDR_WID-1:0] wrapper_addr_o;
  logic [DATA_WID-1:0] wrapper_data_o;
  logic [DATA_WID-1:0] wrapper_data_i;

  modport master (
    input  uartrx_valid_i, uartrx_data_i, uarttx_ready_i,
    input  wrapper_valid_i, wrapper_data_i,
    output uarttx_en_o, uarttx_data_o,
    output wrapper_wr_o, wrapper_en_o, wrapper_addr_o, wrapper_data_o
  );

  modport slave (
    output uartrx_valid_i, uartrx_data_i, uarttx_ready_i,
    output wrapper_valid_i, wrapper_data_i,
    input  uarttx_en_o, uarttx_data_o,
    input  wrapper_wr_o, wrapper_en_o, wrapper_addr_o, wrapper_data_o
  );

endinterface

// File: rtl/uartwb_wbuf.sv
// Write-data buffer of the burst bridge: DEPTH words, filled while the frame
// is received and drained once the frame has been validated.
module uartwb_wbuf #(
  parameter int DEPTH = 16,
  parameter int WID   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  logic           i_wr_en,
  input  logic [WID-1:0] i_wr_data,
  input  logic           i_rd_en,
  output logic [WID-1:0] o_rd_data
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WID-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_wr_ok;

  // Words beyond DEPTH (oversized frames) are dropped; such frames never drain.
  assign w_wr_ok = i_wr_en && (r_wr_ptr < PTR_W'(DEPTH));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and leaving it out keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/uartwb_burst_control.sv
// UART command frames to Wishbone burst reads/writes with checksum, length
// check and UART reply. Define UARTWB_RXTIMEOUT_EN to enable the rx timeout.
module uartwb_burst_control
  import uartwb_pkg::*;
#(
  parameter int ADDR_WID   = 32,
  parameter int DATA_WID   = 32,
  parameter int MAX_BURST  = 16,
  parameter int RX_TIMEOUT = 100000
) (
  input  logic                    clk_i,
  input  logic                    nrst_i,
  uartwb_burst_control_if.master  bus,
  output logic [7:0]              cmdrx_ctr,
  output logic [7:0]              err_ctr
);

  localparam int ADDR_BYTES = ADDR_WID / 8;
  localparam int DATA_BYTES = DATA_WID / 8;

`ifdef UARTWB_RXTIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic [3:0]          r_state;
  logic                r_rx_q;
  logic [7:0]          r_cmd, r_len, r_chk, r_tx_byte;
  logic [3:0]          r_byte_cnt;
  logic [7:0]          r_word_cnt;
  logic                r_is_wr, r_tx_done;
  logic [ADDR_WID-1:0] r_addr, r_wb_addr;
  logic [DATA_WID-1:0] r_wdata, r_wb_data, r_rd_sr;
  logic                r_wb_en, r_wb_wr;
  logic [7:0]          r_cmdrx_ctr, r_err_ctr;
  logic [31:0]         r_to_cnt;

  logic                w_rx_stb, w_in_rx, w_to_fire, w_tx_go, w_len_bad;
  logic                w_last_word, w_addr_done, w_word_done;
  logic [7:0]          w_rx_byte;
  logic [DATA_WID-1:0] w_wdata_next, w_buf_data;
  logic                w_buf_clr, w_buf_wr, w_buf_rd;

  assign w_rx_byte    = bus.uartrx_data_i;
  assign w_rx_stb     = bus.uartrx_valid_i && !r_rx_q;
  assign w_in_rx      = (r_state == S_RX_LEN) || (r_state == S_RX_ADDR) ||
                        (r_state == S_RX_DATA) || (r_state == S_RX_CHK);
  assign w_tx_go      = ((r_state == S_TX_CMD) || (r_state == S_TX_DATA)) && bus.uarttx_ready_i;
  assign w_len_bad    = (r_len == 8'd0) || (r_len > 8'(MAX_BURST));
  assign w_last_word  = (r_word_cnt == r_len - 8'd1);
  assign w_addr_done  = (r_byte_cnt == 4'(ADDR_BYTES - 1));
  assign w_word_done  = (r_byte_cnt == 4'(DATA_BYTES - 1));
  assign w_wdata_next = (r_wdata << 8) | DATA_WID'(w_rx_byte);
  assign w_to_fire    = TO_EN && w_in_rx && !w_rx_stb && (r_to_cnt == 32'(RX_TIMEOUT - 1));

  assign w_buf_clr = (r_state == S_IDLE) && w_rx_stb;
  assign w_buf_wr  = (r_state == S_RX_DATA) && w_rx_stb && w_word_done;
  assign w_buf_rd  = (r_state == S_WB_REQ) && r_is_wr;

  uartwb_wbuf #(.DEPTH(MAX_BURST), .WID(DATA_WID)) u_wbuf (
    .clk       (clk_i),
    .rst_n     (nrst_i),
    .i_clr     (w_buf_clr),
    .i_wr_en   (w_buf_wr),
    .i_wr_data (w_wdata_next),
    .i_rd_en   (w_buf_rd),
    .o_rd_data (w_buf_data)
  );

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) r_rx_q <= 1'b1;
    else         r_rx_q <= bus.uartrx_valid_i;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)                  r_to_cnt <= '0;
    else if (!w_in_rx || w_rx_stb) r_to_cnt <= '0;
    else                          r_to_cnt <= r_to_cnt + 32'd1;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_len       <= '0;
      r_chk       <= '0;
      r_tx_byte   <= '0;
      r_byte_cnt  <= '0;
      r_word_cnt  <= '0;
      r_is_wr     <= 1'b0;
      r_tx_done   <= 1'b0;
      r_addr      <= '0;
      r_wb_addr   <= '0;
      r_wdata     <= '0;
      r_wb_data   <= '0;
      r_rd_sr     <= '0;
      r_wb_en     <= 1'b0;
      r_wb_wr     <= 1'b0;
      r_cmdrx_ctr <= '0;
      r_err_ctr   <= '0;
    end else begin
      r_wb_en <= 1'b0;
      case (r_state)
        S_IDLE: if (w_rx_stb) begin
          r_cmd       <= w_rx_byte;
          r_is_wr     <= (w_rx_byte == CMD_WRITE);
          r_chk       <= CHK_SEED ^ w_rx_byte;
          r_cmdrx_ctr <= r_cmdrx_ctr + 8'd1;
          r_state     <= S_RX_LEN;
        end
        S_RX_LEN: if (w_rx_stb) begin
          r_len      <= w_rx_byte;
          r_chk      <= r_chk ^ w_rx_byte;
          r_byte_cnt <= '0;
          r_state    <= S_RX_ADDR;
        end
        S_RX_ADDR: if (w_rx_stb) begin
          r_addr     <= (r_addr << 8) | ADDR_WID'(w_rx_byte);
          r_chk      <= r_chk ^ w_rx_byte;
          r_byte_cnt <= w_addr_done ? 4'd0 : r_byte_cnt + 4'd1;
          r_word_cnt <= '0;
          if (w_addr_done) r_state <= (r_is_wr && r_len != 8'd0) ? S_RX_DATA : S_RX_CHK;
        end
        S_RX_DATA: if (w_rx_stb) begin
          r_wdata    <= w_wdata_next;
          r_chk      <= r_chk ^ w_rx_byte;
          r_byte_cnt <= w_word_done ? 4'd0 : r_byte_cnt + 4'd1;
          if (w_word_done) begin
            if (w_last_word) r_state <= S_RX_CHK;
            else             r_word_cnt <= r_word_cnt + 8'd1;
          end
        end
        // Folding the received CHK into the running XOR leaves zero on a match.
        S_RX_CHK: if (w_rx_stb) begin
          r_chk   <= r_chk ^ w_rx_byte;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_word_cnt <= '0;
          if (r_chk != 8'd0 || w_len_bad) begin
            r_tx_byte <= (r_chk != 8'd0) ? ST_BADCHK : ST_BADLEN;
            r_tx_done <= 1'b1;
            r_err_ctr <= r_err_ctr + 8'd1;
            r_state   <= S_TX_CMD;
          end else begin
            r_tx_byte <= r_cmd;
            r_tx_done <= r_is_wr;
            r_state   <= r_is_wr ? S_WB_REQ : S_TX_CMD;
          end
        end
        S_TX_CMD: if (w_tx_go) r_state <= r_tx_done ? S_IDLE : S_WB_REQ;
        S_WB_REQ: begin
          r_wb_en   <= 1'b1;
          r_wb_wr   <= r_is_wr;
          r_wb_addr <= r_addr;
          if (r_is_wr) r_wb_data <= w_buf_data;
          r_state   <= S_WB_WAIT;
        end
        S_WB_WAIT: if (bus.wrapper_valid_i) begin
          r_addr <= r_addr + ADDR_WID'(DATA_BYTES);
          if (r_is_wr) begin
            if (w_last_word) r_state <= S_TX_CMD;
            else begin
              r_word_cnt <= r_word_cnt + 8'd1;
              r_state    <= S_WB_REQ;
            end
          end else begin
            r_rd_sr    <= bus.wrapper_data_i;
            r_byte_cnt <= '0;
            r_state    <= S_TX_DATA;
          end
        end
        S_TX_DATA: if (w_tx_go) begin
          r_rd_sr    <= r_rd_sr << 8;
          r_byte_cnt <= w_word_done ? 4'd0 : r_byte_cnt + 4'd1;
          if (w_word_done) begin
            if (w_last_word) r_state <= S_IDLE;
            else begin
              r_word_cnt <= r_word_cnt + 8'd1;
              r_state    <= S_WB_REQ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // A stalled frame is abandoned without any reply.
      if (w_to_fire) begin
        r_state   <= S_IDLE;
        r_err_ctr <= r_err_ctr + 8'd1;
      end
    end
  end

  assign bus.uarttx_en_o    = w_tx_go;
  assign bus.uarttx_data_o  = (r_state == S_TX_DATA) ? r_rd_sr[DATA_WID-1 -: 8] : r_tx_byte;
  assign bus.wrapper_en_o   = r_wb_en;
  assign bus.wrapper_wr_o   = r_wb_wr;
  assign bus.wrapper_addr_o = r_wb_addr;
  assign bus.wrapper_data_o = r_wb_data;
  assign cmdrx_ctr          = r_cmdrx_ctr;
  assign err_ctr            = r_err_ctr;

endmodule

// File: tb/tb_uartwb_burst_control.sv
// Directed bench for uartwb_burst_control: UART frame driver, Wishbone slave
// model with fixed latency, tx byte monitor and hand-computed expectations.
module tb_uartwb_burst_control;
  import uartwb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int TO = 200;

  logic       clk_i = 1'b0;
  logic       nrst_i;
  logic [7:0] cmdrx_ctr, err_ctr;

  uartwb_burst_control_if #(.ADDR_WID(AW), .DATA_WID(DW)) bus ();

  uartwb_burst_control #(
    .ADDR_WID(AW), .DATA_WID(DW), .MAX_BURST(MB), .RX_TIMEOUT(TO)
  ) dut (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .bus       (bus.master),
    .cmdrx_ctr (cmdrx_ctr),
    .err_ctr   (err_ctr)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else             n_pass++;
  endtask

  // ---------------- monitors / slave model (sample on negedge) ----------------
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  int          tx_bad = 0;
  logic [31:0] acc_addr[$];
  logic [31:0] acc_data[$];
  logic        acc_wr[$];
  logic [31:0] rd_q[$];
  int          pend = 0;
  bit          pend_rd = 1'b0;
  bit          slave_stall = 1'b0;
  int          unstable = 0;

  always @(negedge clk_i) begin
    if (bus.uarttx_en_o === 1'b1) begin
      tx_q.push_back(bus.uarttx_data_o);
      if (bus.uarttx_ready_i !== 1'b1) tx_bad++;
    end
  end

  always @(negedge clk_i) begin
    bus.wrapper_valid_i = 1'b0;
    if (pend > 0) begin
      if (bus.wrapper_addr_o !== acc_addr[$] || bus.wrapper_wr_o !== acc_wr[$] ||
          (acc_wr[$] && bus.wrapper_data_o !== acc_data[$]))
        unstable++;
      pend--;
      if (pend == 0) begin
        bus.wrapper_valid_i = 1'b1;
        if (pend_rd) bus.wrapper_data_i = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
      end
    end
    if (bus.wrapper_en_o === 1'b1) begin
      acc_addr.push_back(bus.wrapper_addr_o);
      acc_data.push_back(bus.wrapper_data_o);
      acc_wr.push_back(bus.wrapper_wr_o);
      pend_rd = !bus.wrapper_wr_o;
      if (!slave_stall) pend = 3;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] fchk;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.uartrx_data_i  = b;
    bus.uartrx_valid_i = 1'b1;
    step(2);
    bus.uartrx_valid_i = 1'b0;
    step(2);
  endtask

  task automatic put(input logic [7:0] b);
    fchk = fchk ^ b;
    send_byte(b);
  endtask

  task automatic put_hdr(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] addr);
    fchk = 8'hFF;
    put(cmd);
    put(len);
    for (int i = 3; i >= 0; i--) put(addr[8*i +: 8]);
  endtask

  task automatic put_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) put(w[8*i +: 8]);
  endtask

  task automatic put_chk(input bit bad);
    send_byte(bad ? ~fchk : fchk);
  endtask

  task automatic exp_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic expect_tx(input string tag);
    int cyc = 0;
    while (tx_q.size() < exp_q.size() && cyc < 3000) begin step(1); cyc++; end
    step(20);
    check({tag, "_count"}, 64'(tx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(tx_q[i]), 64'(exp_q[i]));
    tx_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
    if (idx < acc_addr.size()) begin
      check({tag, "_wr"}, 64'(acc_wr[idx]), 64'(wr));
      check({tag, "_addr"}, 64'(acc_addr[idx]), 64'(addr));
      if (wr) check({tag, "_data"}, 64'(acc_data[idx]), 64'(data));
    end else begin
      check({tag, "_present"}, 64'(acc_addr.size()), 64'(idx + 1));
    end
  endtask

  // ---------------- directed sequence ----------------
  int base;

  initial begin
    nrst_i              = 1'b0;
    bus.uartrx_valid_i  = 1'b0;
    bus.uartrx_data_i   = 8'h00;
    bus.uarttx_ready_i  = 1'b1;
    bus.wrapper_data_i  = '0;
    step(3);
    check("rst_tx_en",   64'(bus.uarttx_en_o),    64'd0);
    check("rst_tx_data", 64'(bus.uarttx_data_o),  64'd0);
    check("rst_wb_en",   64'(bus.wrapper_en_o),   64'd0);
    check("rst_wb_wr",   64'(bus.wrapper_wr_o),   64'd0);
    check("rst_wb_addr", 64'(bus.wrapper_addr_o), 64'd0);
    check("rst_wb_data", 64'(bus.wrapper_data_o), 64'd0);
    check("rst_cmdrx",   64'(cmdrx_ctr),          64'd0);
    check("rst_err",     64'(err_ctr),            64'd0);
    nrst_i = 1'b1;
    step(2);

    // Write LEN=2 @0x1000: nothing may reach the bus before CHK
    base = acc_addr.size();
    put_hdr(CMD_WRITE, 8'd2, 32'h0000_1000);
    put_word(32'hA5A5_A5A5);
    put_word(32'h5A5A_5A5A);
    step(5);
    check("wr2_no_early_access", 64'(acc_addr.size()), 64'(base));
    put_chk(1'b0);
    exp_q.push_back(8'h01);
    expect_tx("wr2_tx");
    check("wr2_n_acc", 64'(acc_addr.size() - base), 64'd2);
    chk_acc("wr2_a0", base,     1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
    chk_acc("wr2_a1", base + 1, 1'b1, 32'h0000_1004, 32'h5A5A_5A5A);

    // Read LEN=3 @0x20, slave returns 1,2,3
    base = acc_addr.size();
    rd_q = '{32'd1, 32'd2, 32'd3};
    put_hdr(CMD_READ, 8'd3, 32'h0000_0020);
    put_chk(1'b0);
    exp_q.push_back(8'h00);
    exp_word(32'd1);
    exp_word(32'd2);
    exp_word(32'd3);
    expect_tx("rd3_tx");
    chk_acc("rd3_a0", base,     1'b0, 32'h20, 32'h0);
    chk_acc("rd3_a1", base + 1, 1'b0, 32'h24, 32'h0);
    chk_acc("rd3_a2", base + 2, 1'b0, 32'h28, 32'h0);

    // Read across the address wrap, tx ready dropped for 50 cycles mid-word
    base = acc_addr.size();
    rd_q = '{32'hDEAD_BEEF, 32'h1234_5678};
    put_hdr(CMD_READ, 8'd2, 32'hFFFF_FFFC);
    put_chk(1'b0);
    for (int c = 0; c < 500 && tx_q.size() < 3; c++) step(1);
    bus.uarttx_ready_i = 1'b0;
    step(50);
    check("stall_no_tx", 64'(tx_q.size()), 64'd3);
    bus.uarttx_ready_i = 1'b1;
    exp_q.push_back(8'h00);
    exp_word(32'hDEAD_BEEF);
    exp_word(32'h1234_5678);
    expect_tx("stall_tx");
    chk_acc("wrap_a0", base,     1'b0, 32'hFFFF_FFFC, 32'h0);
    chk_acc("wrap_a1", base + 1, 1'b0, 32'h0000_0000, 32'h0);

    // Bad checksum
    base = acc_addr.size();
    put_hdr(CMD_WRITE, 8'd1, 32'h0000_0200);
    put_word(32'h1234_5678);
    put_chk(1'b1);
    exp_q.push_back(8'hFF);
    expect_tx("badchk_tx");
    check("badchk_no_access", 64'(acc_addr.size()), 64'(base));
    check("badchk_err", 64'(err_ctr), 64'd1);

    // LEN=0 and LEN=MAX_BURST+1
    put_hdr(CMD_WRITE, 8'd0, 32'h0000_0300);
    put_chk(1'b0);
    exp_q.push_back(8'hFE);
    expect_tx("len0_tx");
    put_hdr(CMD_READ, 8'(MB + 1), 32'h0000_0300);
    put_chk(1'b0);
    exp_q.push_back(8'hFE);
    expect_tx("lenbig_tx");
    check("badlen_no_access", 64'(acc_addr.size()), 64'(base));
    check("badlen_err", 64'(err_ctr), 64'd3);

    // LEN=MAX_BURST succeeds
    base = acc_addr.size();
    put_hdr(CMD_WRITE, 8'(MB), 32'h0000_0100);
    for (int k = 1; k <= MB; k++) put_word(32'h1111_1111 * k);
    put_chk(1'b0);
    exp_q.push_back(8'h01);
    expect_tx("lenmax_tx");
    check("lenmax_n_acc", 64'(acc_addr.size() - base), 64'(MB));
    for (int k = 0; k < MB; k++)
      chk_acc($sformatf("lenmax_a%0d", k), base + k, 1'b1, 32'h100 + 32'(4 * k), 32'h1111_1111 * (k + 1));
    check("cmdrx_total", 64'(cmdrx_ctr), 64'd7);
    check("err_total",   64'(err_ctr),   64'd3);

`ifdef UARTWB_RXTIMEOUT_EN
    // Frame abandoned after the address bytes
    put_hdr(CMD_READ, 8'd1, 32'h0000_0040);
    step(TO + 30);
    expect_tx("timeout_tx");
    check("timeout_err",   64'(err_ctr),   64'd4);
    check("timeout_cmdrx", 64'(cmdrx_ctr), 64'd8);
`endif

    // Reset while the bridge waits in WB_WAIT
    slave_stall = 1'b1;
    base = acc_addr.size();
    put_hdr(CMD_READ, 8'd1, 32'h0000_0080);
    put_chk(1'b0);
    for (int c = 0; c < 300 && acc_addr.size() == base; c++) step(1);
    check("hold_access_issued", 64'(acc_addr.size() - base), 64'd1);
    exp_q.push_back(8'h00);
    expect_tx("hold_tx");
    nrst_i = 1'b0;
    #1;
    check("midrst_wb_en",   64'(bus.wrapper_en_o),   64'd0);
    check("midrst_wb_addr", 64'(bus.wrapper_addr_o), 64'd0);
    check("midrst_tx_en",   64'(bus.uarttx_en_o),    64'd0);
    check("midrst_cmdrx",   64'(cmdrx_ctr),          64'd0);
    check("midrst_err",     64'(err_ctr),            64'd0);
    step(3);
    nrst_i      = 1'b1;
    slave_stall = 1'b0;
    step(2);

    // Block must accept a fresh frame from IDLE
    base = acc_addr.size();
    put_hdr(CMD_WRITE, 8'd1, 32'h0000_0044);
    put_word(32'hCAFE_F00D);
    put_chk(1'b0);
    exp_q.push_back(8'h01);
    expect_tx("post_rst_tx");
    chk_acc("post_rst_a0", base, 1'b1, 32'h44, 32'hCAFE_F00D);
    check("post_rst_cmdrx", 64'(cmdrx_ctr), 64'd1);

    check("tx_only_when_ready", 64'(tx_bad),   64'd0);
    check("wb_stable",          64'(unstable), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
